// File: rtl/clk_div_n.sv
// Programmable integer clock divider: 50% duty for even/odd divisors or a
// single-cycle pulse, with glitch-free divisor/mode updates at period ends.
module clk_div_n #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             mode,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             cur_mode_q, cur_mode_d;
    logic             p_q, p_d;
    logic             n_q;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] eff_div;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH:0]   half;
    logic             wrap;

    always_comb begin
        eff_div    = (div < TWO) ? TWO : div;
        wrap       = (cnt_q == cur_div_q - ONE);
        cnt_nxt    = wrap ? '0 : cnt_q + ONE;
        // One extra bit so (2^WIDTH-1)+1 does not overflow
        half       = ({1'b0, cur_div_q} + ONE_X) >> 1;
        cur_div_d  = cur_div_q;
        cur_mode_d = cur_mode_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        tick_d     = 1'b0;
        if (!en) begin
            cnt_d      = eff_div - ONE;
            p_d        = 1'b0;
            cur_div_d  = eff_div;
            cur_mode_d = mode;
        end else begin
            cnt_d  = cnt_nxt;
            tick_d = (cnt_nxt == '0);
            if (cur_mode_q) begin
                p_d = (cnt_nxt == '0);
            end else begin
                p_d = ({1'b0, cnt_nxt} < half);
            end
            if (wrap) begin
                cur_div_d  = eff_div;
                cur_mode_d = mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_div_q  <= DIV_RST;
            cur_mode_q <= 1'b0;
            cnt_q      <= CNT_RST;
            p_q        <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cur_div_q  <= cur_div_d;
            cur_mode_q <= cur_mode_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            tick_q     <= tick_d;
        end
    end

    // Half-cycle delayed copy stretches odd-divisor high phase by 0.5 cycle
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

    assign clk_out = (!cur_mode_q && cur_div_q[0]) ? (p_q & n_q) : p_q;
    assign tick    = tick_q;
    assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Directed self-checking bench for clk_div_n.
module tb_clk_div_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       mode;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;

    int n_cmp = 0;
    int n_err = 0;

    longint r_last = 0, r_prev = 0, f_last = 0, tk_last = 0, tk_prev = 0;
    int     r_cnt = 0, f_cnt = 0, tk_cnt = 0;

    clk_div_n #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .mode    (mode),
        .clk_out (clk_out),
        .tick    (tick),
        .cur_div (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk_out) begin
        r_prev = r_last;
        r_last = $time;
        r_cnt++;
    end
    always @(negedge clk_out) begin
        f_last = $time;
        f_cnt++;
    end
    always @(posedge tick) begin
        tk_prev = tk_last;
        tk_last = $time;
        tk_cnt++;
    end

    task automatic wait_rise(input int lim, output bit ok);
        int s;
        s  = r_cnt;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            #1;
            if (r_cnt != s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fall(input int lim, output bit ok);
        int s;
        s  = f_cnt;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            #1;
            if (f_cnt != s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tick(input int lim, output bit ok);
        int s;
        s  = tk_cnt;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            #1;
            if (tk_cnt != s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic measure(output longint hi, output longint lo, output bit ok);
        bit a, b, c;
        longint t0, t1;
        wait_rise(6000, a);
        t0 = r_last;
        wait_fall(6000, b);
        t1 = f_last;
        wait_rise(6000, c);
        hi = t1 - t0;
        lo = r_last - t1;
        ok = a & b & c;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (clk_out !== 1'b0) begin
            n_err++;
            $display("FAIL rst_clk_out: got %b want 0", clk_out);
        end
        n_cmp++;
        if (tick !== 1'b0) begin
            n_err++;
            $display("FAIL rst_tick: got %b want 0", tick);
        end
        n_cmp++;
        if (cur_div !== 8'd2) begin
            n_err++;
            $display("FAIL rst_cur_div: got %0d want 2", cur_div);
        end
    endtask

    task automatic test_start();
        longint tp, hi, lo;
        bit ok;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        @(posedge clk);
        tp = $time;
        #1;
        n_cmp++;
        if (tick !== 1'b1 || clk_out !== 1'b1) begin
            n_err++;
            $display("FAIL start_first_edge: got tick=%b clk_out=%b want 1/1", tick, clk_out);
        end
        n_cmp++;
        if (cur_div !== 8'd4) begin
            n_err++;
            $display("FAIL start_cur_div: got %0d want 4", cur_div);
        end
        wait_fall(200, ok);
        n_cmp++;
        if (!ok || f_last != tp + 20) begin
            n_err++;
            $display("FAIL start_first_fall: got %0d want %0d", f_last, tp + 20);
        end
        measure(hi, lo, ok);
        n_cmp++;
        if (!ok || hi != 20 || lo != 20) begin
            n_err++;
            $display("FAIL div4_duty: got %0d/%0d want 20/20", hi, lo);
        end
        n_cmp++;
        if (tk_last - tk_prev != 40) begin
            n_err++;
            $display("FAIL div4_tick_period: got %0d want 40", tk_last - tk_prev);
        end
    endtask

    task automatic test_odd();
        longint hi, lo;
        bit ok;
        @(negedge clk);
        div = 8'd3;
        measure(hi, lo, ok);
        measure(hi, lo, ok);
        n_cmp++;
        if (!ok || hi != 15 || lo != 15) begin
            n_err++;
            $display("FAIL div3_duty: got %0d/%0d want 15/15", hi, lo);
        end
        n_cmp++;
        if (r_last - tk_last != 5) begin
            n_err++;
            $display("FAIL div3_rise_lag: got %0d want 5", r_last - tk_last);
        end
        @(negedge clk);
        div = 8'd255;
        measure(hi, lo, ok);
        measure(hi, lo, ok);
        n_cmp++;
        if (!ok || hi != 1275 || lo != 1275) begin
            n_err++;
            $display("FAIL div255_duty: got %0d/%0d want 1275/1275", hi, lo);
        end
        n_cmp++;
        if (cur_div !== 8'd255) begin
            n_err++;
            $display("FAIL div255_cur_div: got %0d want 255", cur_div);
        end
    endtask

    task automatic test_pulse();
        longint hi, lo;
        bit ok;
        @(negedge clk);
        div  = 8'd5;
        mode = 1'b1;
        measure(hi, lo, ok);
        measure(hi, lo, ok);
        n_cmp++;
        if (!ok || hi != 10 || lo != 40) begin
            n_err++;
            $display("FAIL pulse_shape: got %0d/%0d want 10/40", hi, lo);
        end
        n_cmp++;
        if (r_last != tk_last) begin
            n_err++;
            $display("FAIL pulse_tick_align: got %0d want %0d", tk_last, r_last);
        end
    endtask

    task automatic test_mid_change();
        longint hi, lo, t0;
        bit ok;
        @(negedge clk);
        div  = 8'd4;
        mode = 1'b0;
        measure(hi, lo, ok);
        wait_tick(200, ok);
        t0 = tk_last;
        @(negedge clk);
        @(negedge clk);
        div = 8'd6;
        #20;
        n_cmp++;
        if (cur_div !== 8'd4 || f_last != t0 + 20) begin
            n_err++;
            $display("FAIL mid_old_period: got cur_div=%0d fall=%0d want 4/%0d", cur_div, f_last, t0 + 20);
        end
        wait_rise(200, ok);
        n_cmp++;
        if (!ok || r_last != t0 + 40 || cur_div !== 8'd6) begin
            n_err++;
            $display("FAIL mid_boundary: got rise=%0d cur_div=%0d want %0d/6", r_last, cur_div, t0 + 40);
        end
        wait_fall(200, ok);
        n_cmp++;
        if (!ok || f_last != t0 + 70) begin
            n_err++;
            $display("FAIL mid_new_high: got %0d want %0d", f_last, t0 + 70);
        end
        wait_rise(200, ok);
        n_cmp++;
        if (!ok || r_last != t0 + 100) begin
            n_err++;
            $display("FAIL mid_new_period: got %0d want %0d", r_last, t0 + 100);
        end
    endtask

    task automatic test_clamp_enable();
        longint hi, lo, r0, te;
        int rc;
        bit ok;
        @(negedge clk);
        div = 8'd0;
        measure(hi, lo, ok);
        measure(hi, lo, ok);
        n_cmp++;
        if (!ok || hi != 10 || lo != 10 || cur_div !== 8'd2) begin
            n_err++;
            $display("FAIL clamp_div0: got %0d/%0d cur_div=%0d want 10/10/2", hi, lo, cur_div);
        end
        @(negedge clk);
        div = 8'd6;
        measure(hi, lo, ok);
        wait_rise(200, ok);
        r0 = r_last;
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (clk_out !== 1'b0 || tick !== 1'b0 || f_last != r0 + 10) begin
            n_err++;
            $display("FAIL en_drop: got clk_out=%b tick=%b fall=%0d want 0/0/%0d", clk_out, tick, f_last, r0 + 10);
        end
        rc = r_cnt;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (r_cnt != rc || clk_out !== 1'b0 || cur_div !== 8'd6) begin
            n_err++;
            $display("FAIL en_parked: got rises=%0d clk_out=%b cur_div=%0d want 0/0/6", r_cnt - rc, clk_out, cur_div);
        end
        en = 1'b1;
        te = $time;
        @(posedge clk);
        #1;
        n_cmp++;
        if (clk_out !== 1'b1 || tick !== 1'b1) begin
            n_err++;
            $display("FAIL en_restart: got clk_out=%b tick=%b want 1/1", clk_out, tick);
        end
        wait_fall(200, ok);
        n_cmp++;
        if (!ok || f_last != te + 35) begin
            n_err++;
            $display("FAIL en_full_period: got %0d want %0d", f_last, te + 35);
        end
    endtask

    task automatic test_async_reset();
        longint tr;
        int rc;
        bit ok;
        wait_tick(200, ok);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (!ok || clk_out !== 1'b0 || tick !== 1'b0 || cur_div !== 8'd2) begin
            n_err++;
            $display("FAIL async_rst: got clk_out=%b tick=%b cur_div=%0d want 0/0/2", clk_out, tick, cur_div);
        end
        rc = r_cnt;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (r_cnt != rc || clk_out !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_runt: got rises=%0d clk_out=%b want 0/0", r_cnt - rc, clk_out);
        end
        rst = 1'b0;
        tr  = $time;
        @(posedge clk);
        #1;
        n_cmp++;
        if (clk_out !== 1'b1 || tick !== 1'b1 || cur_div !== 8'd6) begin
            n_err++;
            $display("FAIL rst_restart: got clk_out=%b tick=%b cur_div=%0d want 1/1/6", clk_out, tick, cur_div);
        end
        wait_fall(200, ok);
        n_cmp++;
        if (!ok || f_last != tr + 35) begin
            n_err++;
            $display("FAIL rst_restart_high: got %0d want %0d", f_last, tr + 35);
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        div  = 8'd4;
        mode = 1'b0;
        test_reset();
        test_start();
        test_odd();
        test_pulse();
        test_mid_change();
        test_clamp_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_n.md
Name: clk_div_n

Overview:
Programmable integer clock divider. It is the parametrised successor of the team's fixed divide-by-2 toggle divider. It divides clk by a runtime divisor of 2..2^WIDTH-1. It provides a true 50% duty cycle for both even and odd divisors, using a negedge phase register for odd divisors, plus a single-cycle pulse mode. Divisor and mode changes are applied glitch-free at period boundaries. It feeds baud/sample-rate generators and slow peripheral clocks. It also provides a one-cycle tick strobe in the clk domain for logic that must not use clk_out as a clock.

Parameters:
WIDTH, 8, bit width of divisor input and internal counter.
DEFAULT_DIV, 2, active divisor after reset; legal range 2..2^WIDTH-1.

Ports:
clk  input  1  input clock.
rst  input  1  reset, asynchronous, active-high.
en  input  1  run enable; 0 parks the divider with output low.
div  input  WIDTH  requested divisor; values 0 and 1 are clamped to 2.
mode  input  1  0 = 50% duty, 1 = pulse (high for one clk cycle per period).
clk_out  output  1  divided clock.
tick  output  1  one-cycle strobe in the clk domain, high on the cycle the period restarts.
cur_div  output  WIDTH  active divisor currently in use.

Behaviour:
- Reset (async, rst=1): cur_div=DEFAULT_DIV, cur_mode=0, cnt=DEFAULT_DIV-1, p=0, n=0, tick=0. clk_out=0 immediately.
- Clamp rule: eff_div = (div<2) ? 2 : div.
- Shadow load: cur_div<=eff_div and cur_mode<=mode only on a boundary edge (en=1 and cnt==cur_div-1) or on any edge with en=0. Changes at other times have no effect until the next boundary. The period in progress always completes with the old settings.
- Posedge, en=1: cnt_next = (cnt==cur_div-1) ? 0 : cnt+1; cnt<=cnt_next.
- The p register is computed from cnt_next, using the settings active before the edge:
  - mode 0: p <= (cnt_next < H), where H=(cur_div+1)/2 (integer divide).
  - mode 1: p <= (cnt_next==0).
- tick <= (cnt_next==0) & en. tick rises on the same edge as p in every mode.
- Negedge: n <= p. n is reset asynchronously.
- clk_out:
  - mode 0 with odd cur_div: clk_out = p & n.
  - All other cases (mode 0 with even cur_div, and mode 1): clk_out = p.
  - The output mux selects on registered cur_div[0] and cur_mode only, so the select never changes mid-period.
- Resulting waveforms:
  - Even D: high D/2, low D/2 cycles.
  - Odd D: high D/2 cycles exactly (half-cycle resolution). The rising edge lags the tick edge by half a clk cycle.
  - Mode 1: high 1 cycle, low D-1 cycles.
  - Period is exactly cur_div clk cycles in all modes.
- en=0 at a posedge: cnt<=eff_div-1, p<=0, tick<=0, shadow loads. clk_out falls within half a cycle, which may truncate a high phase. This truncation is the accepted stop behaviour.
- First enabled edge after reset or after en=0: cnt wraps to 0. p and tick rise on that edge, so the first period is full-length.
- Reset mid-period: clk_out drops asynchronously with no runt pulse generated afterwards. Restart follows the rule above.
- Wrap: the counter never exceeds cur_div-1. div=2^WIDTH-1 is legal and must not overflow.

Test Plan:
- Reset/start, clk period 10 ns, div=4, mode=0, en=1 after rst release -> tick and clk_out rise on first edge. clk_out is 20 ns high / 20 ns low. tick repeats every 40 ns. cur_div=4.
- Odd 50%, div=3, mode=0 -> clk_out 15 ns high / 15 ns low. Rising edge 5 ns after tick's rising clk edge. Repeat with div=255: 1275 ns high / 1275 ns low.
- Pulse mode, div=5, mode=1 -> clk_out high exactly 10 ns every 50 ns, coincident with tick.
- Mid-period change: running div=4, set div=6 at cnt==1 -> current period stays 40 ns. The next period is 60 ns (30/30). cur_div changes to 6 on the boundary edge only, with no glitch shorter than 20 ns.
- Clamp and enable: div=0 -> cur_div=2, 10/10 ns output. Drop en during a high phase -> clk_out low within 5 ns, tick=0. Re-enable -> full period starts on first edge.
- Async reset at cnt==2 of div=6 -> clk_out, tick go 0 immediately and cur_div=DEFAULT_DIV. Normal restart after release.
